// File: rtl/req_prio_encoder8_pkg.sv
// Shared constants, FSM state type and index-to-one-hot helper for the
// registered 8-to-3 priority encoder.
package req_prio_encoder8_pkg;

    localparam int N_IN   = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    // Index to one-hot, same truth table as the 3-to-8 decoder.
    function automatic logic [N_IN-1:0] idx2onehot(input logic [CODE_W-1:0] idx);
        logic [N_IN-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/prio_enc8_comb.sv
// Combinational 8-to-3 priority encoder: highest set bit wins.
module prio_enc8_comb (
    input  logic [7:0] vec,
    output logic [2:0] idx,
    output logic       nz
);

    // Scan upwards so the last (highest) set bit overrides lower ones.
    always_comb begin
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (vec[i]) idx = 3'(i);
        end
        nz = |vec;
    end

endmodule

// File: rtl/req_prio_encoder8.sv
// Sticky request capture with a registered, handshaked priority code.
// A code stays stable until accepted; accepts clear their pending bit and
// may load the next code in the same cycle for back-to-back delivery.
module req_prio_encoder8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       flush,
    input  logic [7:0] req,
    output logic [2:0] code,
    output logic       code_valid,
    input  logic       code_ready,
    output logic [7:0] pending,
    output logic       any_pending
);
    import req_prio_encoder8_pkg::*;

    state_e            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [N_IN-1:0]   pending_q, pending_d;

    logic              accept;
    logic [N_IN-1:0]   clr;
    logic [N_IN-1:0]   rem;
    logic [CODE_W-1:0] pend_idx, rem_idx;
    logic              pend_nz, rem_nz;

    // IDLE loads look at the full pending set.
    prio_enc8_comb u_enc_pend (
        .vec (pending_q),
        .idx (pend_idx),
        .nz  (pend_nz)
    );

    // Back-to-back loads look at what is left after the accepted bit clears;
    // requests arriving this cycle are deliberately excluded.
    prio_enc8_comb u_enc_rem (
        .vec (rem),
        .idx (rem_idx),
        .nz  (rem_nz)
    );

    assign code_valid  = (state_q == PRESENT);
    assign code        = code_q;
    assign pending     = pending_q;
    assign any_pending = |pending_q;

    // Next pending set: accepted bit clears, new requests set (set wins).
    always_comb begin
        accept = code_valid & code_ready;
        clr    = accept ? idx2onehot(code_q) : '0;
        rem    = pending_q & ~clr;
        if (flush) pending_d = '0;
        else       pending_d = rem | (en ? req : '0);
    end

    // Presentation FSM; flush drops the code without touching its value.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en && pend_nz) begin
                        code_d  = pend_idx;
                        state_d = PRESENT;
                    end
                end
                PRESENT: begin
                    if (code_ready) begin
                        if (en && rem_nz) code_d = rem_idx;
                        else              state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, code and pending registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            code_q    <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: tb/tb_req_prio_encoder8.sv
// Bench for req_prio_encoder8: directed vector table, async reset sequence,
// then randomized traffic against a bit-level reference model.
module tb_req_prio_encoder8;
    import req_prio_encoder8_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] req = '0;
    logic       code_ready = 1'b0;
    logic [2:0] code;
    logic       code_valid;
    logic [7:0] pending;
    logic       any_pending;

    req_prio_encoder8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .flush       (flush),
        .req         (req),
        .code        (code),
        .code_valid  (code_valid),
        .code_ready  (code_ready),
        .pending     (pending),
        .any_pending (any_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       flush;
        logic [7:0] req;
        logic       rdy;
        logic [7:0] exp_pend;
        logic       exp_vld;
        logic [2:0] exp_code;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state
    logic [7:0] m_pend;
    logic       m_vld;
    logic [2:0] m_code;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic e, input logic f, input logic [7:0] r, input logic rd,
                       input logic [7:0] ep, input logic ev, input logic [2:0] ec);
        vec_t v;
        v.en = e; v.flush = f; v.req = r; v.rdy = rd;
        v.exp_pend = ep; v.exp_vld = ev; v.exp_code = ec;
        vecs.push_back(v);
    endtask

    function automatic logic [2:0] highest(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) if (v[i]) return 3'(i);
        return 3'd0;
    endfunction

    task automatic check_outputs(input string tag, input logic [7:0] ep, input logic ev, input logic [2:0] ec);
        chk({tag, ".pending"}, 32'(pending), 32'(ep));
        chk({tag, ".any_pending"}, 32'(any_pending), 32'(ep != 0));
        chk({tag, ".code_valid"}, 32'(code_valid), 32'(ev));
        if (ev) chk({tag, ".code"}, 32'(code), 32'(ec));
    endtask

    initial begin
        // Single request, latency and accept
        add(1, 0, 8'h04, 0, 8'h04, 0, 0);
        add(1, 0, 8'h00, 0, 8'h04, 1, 2);
        add(1, 0, 8'h00, 1, 8'h00, 0, 0);
        // Priority and back-to-back delivery
        add(1, 0, 8'h91, 1, 8'h91, 0, 0);
        add(1, 0, 8'h00, 1, 8'h91, 1, 7);
        add(1, 0, 8'h00, 1, 8'h11, 1, 4);
        add(1, 0, 8'h00, 1, 8'h01, 1, 0);
        add(1, 0, 8'h00, 1, 8'h00, 0, 0);
        // Stall, no preemption
        add(1, 0, 8'h02, 0, 8'h02, 0, 0);
        add(1, 0, 8'h00, 0, 8'h02, 1, 1);
        add(1, 0, 8'h80, 0, 8'h82, 1, 1);
        add(1, 0, 8'h00, 0, 8'h82, 1, 1);
        add(1, 0, 8'h00, 1, 8'h80, 1, 7);
        add(1, 0, 8'h00, 1, 8'h00, 0, 0);
        // Set wins over clear on collision
        add(1, 0, 8'h08, 0, 8'h08, 0, 0);
        add(1, 0, 8'h00, 0, 8'h08, 1, 3);
        add(1, 0, 8'h08, 1, 8'h08, 0, 0);
        add(1, 0, 8'h00, 0, 8'h08, 1, 3);
        add(1, 0, 8'h00, 1, 8'h00, 0, 0);
        // en gating
        add(0, 0, 8'hFF, 0, 8'h00, 0, 0);
        add(0, 0, 8'h00, 0, 8'h00, 0, 0);
        add(1, 0, 8'h24, 0, 8'h24, 0, 0);
        add(1, 0, 8'h00, 0, 8'h24, 1, 5);
        add(0, 0, 8'h00, 1, 8'h04, 0, 0);
        add(0, 0, 8'h00, 0, 8'h04, 0, 0);
        add(1, 0, 8'h00, 0, 8'h04, 1, 2);
        add(1, 0, 8'h00, 1, 8'h00, 0, 0);
        // Flush with simultaneous handshake and request
        add(1, 0, 8'h3C, 0, 8'h3C, 0, 0);
        add(1, 0, 8'h00, 0, 8'h3C, 1, 5);
        add(1, 1, 8'h01, 1, 8'h00, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00, 0, 0);

        // Shared helper against plain shift
        for (int i = 0; i < 8; i++) begin
            logic [7:0] ref_oh;
            ref_oh = 8'd1 << i;
            chk("idx2onehot", 32'(idx2onehot(3'(i))), 32'(ref_oh));
        end

        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset", 8'h00, 1'b0, 3'd0);
        rst_n = 1'b1;

        // Directed table
        foreach (vecs[k]) begin
            en = vecs[k].en; flush = vecs[k].flush; req = vecs[k].req; code_ready = vecs[k].rdy;
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", k), vecs[k].exp_pend, vecs[k].exp_vld, vecs[k].exp_code);
        end

        // Asynchronous reset mid-handshake
        en = 1; flush = 0; req = 8'h10; code_ready = 0;
        @(posedge clk); #1;
        req = 8'h00;
        @(posedge clk); #1;
        check_outputs("pre_arst", 8'h10, 1'b1, 3'd4);
        #3 rst_n = 1'b0;
        #1;
        check_outputs("arst", 8'h00, 1'b0, 3'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Randomized traffic vs reference model
        m_pend = '0; m_vld = 1'b0; m_code = '0;
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] rem;
            logic       acc;
            en         = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 31) == 0);
            req        = 8'($urandom) & 8'($urandom) & 8'($urandom);
            code_ready = $urandom_range(0, 1) == 1;

            acc = m_vld && code_ready;
            rem = acc ? (m_pend & ~(8'd1 << m_code)) : m_pend;
            if (flush) begin
                m_vld  = 1'b0;
                m_pend = '0;
            end else begin
                if (!m_vld) begin
                    if (en && m_pend != 0) begin
                        m_vld  = 1'b1;
                        m_code = highest(m_pend);
                    end
                end else if (code_ready) begin
                    if (en && rem != 0) m_code = highest(rem);
                    else                m_vld  = 1'b0;
                end
                m_pend = rem | (en ? req : 8'h00);
            end

            @(posedge clk); #1;
            check_outputs("rand", m_pend, m_vld, m_code);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
